sprite_anim_sequencer: RTL and testbench

Multi-channel sprite animation frame sequencer in the pixel clock domain. It replaces the ad-hoc single ping-pong frame counter next to the sprite pipeline with NUM_CHANNELS independently configured animators, each with its own mode, frame range and playback rate. It advances every channel once per video frame on new_frame from video_sig_gen and presents per-channel frame indices to the sprite processor and graphics path.

---
 rtl/anim_pkg.sv | 41 ++++
 rtl/anim_channel_step.sv | 80 ++++++++
 rtl/sprite_anim_sequencer.sv | 125 ++++++++++++
 tb/tb_sprite_anim_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// rtl/anim_pkg.sv - shared types and helpers for the sprite animation sequencer
package anim_pkg;

    typedef enum logic [1:0] {
        MODE_STOP     = 2'd0,
        MODE_LOOP     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_ONESHOT  = 2'd3
    } anim_mode_t;

    typedef enum logic {
        DIR_FWD  = 1'b0,
        DIR_BACK = 1'b1
    } anim_dir_t;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_SCAN = 1'b1
    } seq_state_t;

    // Default widths (NUM_FRAMES=5, PERIOD_W=4); modules rebuild the same
    // layout locally from their own parameters.
    localparam int ANIM_FRAME_W  = 3;
    localparam int ANIM_PERIOD_W = 4;

    typedef struct packed {
        anim_mode_t               mode;
        logic [ANIM_FRAME_W-1:0]  last;
        logic [ANIM_PERIOD_W-1:0] period;
        logic [ANIM_FRAME_W-1:0]  frame;
        logic [ANIM_PERIOD_W-1:0] tick;
        anim_dir_t                dir;
        logic                     done;
    } anim_ch_t;

    // Packed width of one channel record for given field widths.
    function automatic int anim_state_width(input int frame_w, input int period_w);
        return 2 + 2 * frame_w + 2 * period_w + 2;
    endfunction

endpackage

// File: rtl/anim_channel_step.sv
// rtl/anim_channel_step.sv - combinational one-step advance of a single animator
//
// Ports:
//   cur_in   - packed channel record (mode, last, period, frame, tick, dir, done)
//   next_out - the record after one video-frame step
module anim_channel_step
    import anim_pkg::*;
#(
    parameter int FRAME_W  = ANIM_FRAME_W,
    parameter int PERIOD_W = ANIM_PERIOD_W,
    parameter int ST_W     = anim_state_width(FRAME_W, PERIOD_W)
) (
    input  logic [ST_W-1:0] cur_in,
    output logic [ST_W-1:0] next_out
);

    typedef struct packed {
        anim_mode_t          mode;
        logic [FRAME_W-1:0]  last;
        logic [PERIOD_W-1:0] period;
        logic [FRAME_W-1:0]  frame;
        logic [PERIOD_W-1:0] tick;
        anim_dir_t           dir;
        logic                done;
    } ch_t;

    ch_t cur;
    ch_t nxt;

    assign cur      = ch_t'(cur_in);
    assign next_out = nxt;

    always_comb begin
        nxt = cur;
        if (cur.mode == MODE_STOP || cur.done) begin
            nxt = cur;
        end else if (cur.tick < cur.period) begin
            nxt.tick = cur.tick + 1'b1;
        end else begin
            nxt.tick = '0;
            case (cur.mode)
                MODE_LOOP: begin
                    nxt.frame = (cur.frame >= cur.last) ? '0 : cur.frame + 1'b1;
                end
                MODE_PINGPONG: begin
                    // End frames are shown once: turn around by stepping
                    // immediately to the neighbour.
                    if (cur.last == '0) begin
                        nxt.frame = '0;
                    end else if (cur.dir == DIR_FWD) begin
                        if (cur.frame >= cur.last) begin
                            nxt.dir   = DIR_BACK;
                            nxt.frame = cur.frame - 1'b1;
                        end else begin
                            nxt.frame = cur.frame + 1'b1;
                        end
                    end else begin
                        if (cur.frame == '0) begin
                            nxt.dir   = DIR_FWD;
                            nxt.frame = cur.frame + 1'b1;
                        end else begin
                            nxt.frame = cur.frame - 1'b1;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (cur.frame < cur.last) begin
                        nxt.frame = cur.frame + 1'b1;
                    end
                    // Covers last=0 too: done on the very first step.
                    nxt.done = (nxt.frame >= cur.last);
                end
                default: begin
                    nxt = cur;
                end
            endcase
        end
    end

endmodule

// File: rtl/sprite_anim_sequencer.sv
// rtl/sprite_anim_sequencer.sv - multi-channel sprite frame sequencer, one channel stepped per cycle after new_frame
//
// Ports:
//   clk_pixel_in, rst_in          - pixel clock, async active-high reset
//   new_frame_in                  - frame-start pulse; dropped (and counted) while scanning
//   cfg_valid_in/cfg_ready_out    - config handshake, ready only while idle
//   cfg_channel_in/mode/last/period - config payload
//   frame_out, done_out           - per-channel current frame and ONESHOT completion
//   update_done_out               - one-cycle pulse when a scan finishes
//   overrun_count_out             - saturating count of dropped new_frame pulses
module sprite_anim_sequencer
    import anim_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int NUM_FRAMES   = 5,
    parameter int PERIOD_W     = 4,
    parameter int FRAME_W      = $clog2(NUM_FRAMES),
    parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                 clk_pixel_in,
    input  logic                                 rst_in,
    input  logic                                 new_frame_in,
    input  logic                                 cfg_valid_in,
    output logic                                 cfg_ready_out,
    input  logic [CH_W-1:0]                      cfg_channel_in,
    input  logic [1:0]                           cfg_mode_in,
    input  logic [FRAME_W-1:0]                   cfg_last_in,
    input  logic [PERIOD_W-1:0]                  cfg_period_in,
    output logic [NUM_CHANNELS-1:0][FRAME_W-1:0] frame_out,
    output logic [NUM_CHANNELS-1:0]              done_out,
    output logic                                 update_done_out,
    output logic [7:0]                           overrun_count_out
);

    localparam int ST_W = anim_state_width(FRAME_W, PERIOD_W);
    localparam logic [FRAME_W-1:0] LAST_MAX = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [CH_W-1:0]    IDX_END  = CH_W'(NUM_CHANNELS - 1);
    localparam logic [CH_W:0]      CH_COUNT = (CH_W + 1)'(NUM_CHANNELS);

    typedef struct packed {
        anim_mode_t          mode;
        logic [FRAME_W-1:0]  last;
        logic [PERIOD_W-1:0] period;
        logic [FRAME_W-1:0]  frame;
        logic [PERIOD_W-1:0] tick;
        anim_dir_t           dir;
        logic                done;
    } ch_t;

    ch_t               ch_q [NUM_CHANNELS];
    seq_state_t        state_q;
    logic [CH_W-1:0]   idx_q;
    ch_t               cfg_entry;
    logic [ST_W-1:0]   step_cur;
    logic [ST_W-1:0]   step_next;
    logic              cfg_in_range;

    assign cfg_ready_out = (state_q == SEQ_IDLE);
    assign cfg_in_range  = ({1'b0, cfg_channel_in} < CH_COUNT);
    assign step_cur      = ch_q[idx_q];

    anim_channel_step #(
        .FRAME_W  (FRAME_W),
        .PERIOD_W (PERIOD_W),
        .ST_W     (ST_W)
    ) u_step (
        .cur_in   (step_cur),
        .next_out (step_next)
    );

    // Fresh record for a config write: position, tick, dir and done cleared.
    always_comb begin
        cfg_entry        = '0;
        cfg_entry.mode   = anim_mode_t'(cfg_mode_in);
        cfg_entry.last   = (cfg_last_in > LAST_MAX) ? LAST_MAX : cfg_last_in;
        cfg_entry.period = cfg_period_in;
    end

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                ch_q[i] <= '0;
            end
            state_q           <= SEQ_IDLE;
            idx_q             <= '0;
            update_done_out   <= 1'b0;
            overrun_count_out <= '0;
        end else begin
            update_done_out <= 1'b0;
            case (state_q)
                SEQ_IDLE: begin
                    // Config lands before the scan that may start this same edge.
                    if (cfg_valid_in && cfg_in_range) begin
                        ch_q[cfg_channel_in] <= cfg_entry;
                    end
                    if (new_frame_in) begin
                        state_q <= SEQ_SCAN;
                        idx_q   <= '0;
                    end
                end
                SEQ_SCAN: begin
                    ch_q[idx_q] <= ch_t'(step_next);
                    if (new_frame_in && overrun_count_out != 8'hFF) begin
                        overrun_count_out <= overrun_count_out + 8'd1;
                    end
                    if (idx_q == IDX_END) begin
                        state_q         <= SEQ_IDLE;
                        update_done_out <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            frame_out[i] = ch_q[i].frame;
            done_out[i]  = ch_q[i].done;
        end
    end

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// tb/tb_sprite_anim_sequencer.sv - self-checking bench with closed-form animation model
module tb_sprite_anim_sequencer;

    localparam int N = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              new_frame = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [2:0]        cfg_channel = '0;
    logic [1:0]        cfg_mode = '0;
    logic [2:0]        cfg_last = '0;
    logic [3:0]        cfg_period = '0;
    logic [N-1:0][2:0] frame_out;
    logic [N-1:0]      done_out;
    logic              update_done;
    logic [7:0]        overrun;

    int compared   = 0;
    int mismatched = 0;

    int m_mode   [N];
    int m_last   [N];
    int m_period [N];
    int m_n      [N];
    int m_drops  = 0;

    always #5 clk = ~clk;

    sprite_anim_sequencer #(
        .NUM_CHANNELS (N),
        .NUM_FRAMES   (5),
        .PERIOD_W     (4)
    ) dut (
        .clk_pixel_in      (clk),
        .rst_in            (rst),
        .new_frame_in      (new_frame),
        .cfg_valid_in      (cfg_valid),
        .cfg_ready_out     (cfg_ready),
        .cfg_channel_in    (cfg_channel),
        .cfg_mode_in       (cfg_mode),
        .cfg_last_in       (cfg_last),
        .cfg_period_in     (cfg_period),
        .frame_out         (frame_out),
        .done_out          (done_out),
        .update_done_out   (update_done),
        .overrun_count_out (overrun)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Model: m_n counts scans since config; steps = m_n / (period+1).
    function automatic int exp_frame(input int c);
        int s, l, p;
        s = m_n[c] / (m_period[c] + 1);
        l = m_last[c];
        case (m_mode[c])
            1: return s % (l + 1);
            2: begin
                if (l == 0) return 0;
                p = s % (2 * l);
                return (p <= l) ? p : 2 * l - p;
            end
            3: return (s < l) ? s : l;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_done(input int c);
        int s;
        s = m_n[c] / (m_period[c] + 1);
        return (m_mode[c] == 3) && (s >= ((m_last[c] == 0) ? 1 : m_last[c]));
    endfunction

    function automatic logic [N-1:0][2:0] model_frames();
        logic [N-1:0][2:0] v;
        for (int c = 0; c < N; c++) v[c] = 3'(exp_frame(c));
        return v;
    endfunction

    function automatic logic [N-1:0] model_dones();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = exp_done(c);
        return v;
    endfunction

    task automatic model_cfg(input int ch, input int mode, input int last, input int period);
        if (ch < N) begin
            m_mode[ch]   = mode;
            m_last[ch]   = (last > 4) ? 4 : last;
            m_period[ch] = period;
            m_n[ch]      = 0;
        end
    endtask

    task automatic reset_model();
        for (int c = 0; c < N; c++) begin
            m_mode[c] = 0; m_last[c] = 0; m_period[c] = 0; m_n[c] = 0;
        end
        m_drops = 0;
    endtask

    task automatic drive_cfg(input int ch, input int mode, input int last, input int period);
        cfg_valid   = 1'b1;
        cfg_channel = 3'(ch);
        cfg_mode    = 2'(mode);
        cfg_last    = 3'(last);
        cfg_period  = 4'(period);
    endtask

    task automatic do_cfg(input int ch, input int mode, input int last, input int period);
        compared++;
        if (cfg_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL cfg_ready_idle: got %0b want 1", cfg_ready);
        end
        drive_cfg(ch, mode, last, period);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        model_cfg(ch, mode, last, period);
        compared++;
        if (frame_out !== model_frames() || done_out !== model_dones()) begin
            mismatched++;
            $display("FAIL cfg_write ch%0d: got f=%h d=%b want f=%h d=%b",
                     ch, frame_out, done_out, model_frames(), model_dones());
        end
    endtask

    // One accepted new_frame, checking each channel lands on its own edge.
    task automatic run_frame(input bit with_cfg, input int ch, input int mode,
                             input int last, input int period);
        logic [N-1:0][2:0] pre_f, post_f, exp_f;
        logic [N-1:0]      pre_d, post_d, exp_d;
        new_frame = 1'b1;
        if (with_cfg) drive_cfg(ch, mode, last, period);
        @(posedge clk); #1;
        new_frame = 1'b0;
        cfg_valid = 1'b0;
        if (with_cfg) model_cfg(ch, mode, last, period);
        pre_f = model_frames();
        pre_d = model_dones();
        compared++;
        if (cfg_ready !== 1'b0 || frame_out !== pre_f || done_out !== pre_d) begin
            mismatched++;
            $display("FAIL scan_start: got rdy=%0b f=%h d=%b want rdy=0 f=%h d=%b",
                     cfg_ready, frame_out, done_out, pre_f, pre_d);
        end
        for (int c = 0; c < N; c++) m_n[c]++;
        post_f = model_frames();
        post_d = model_dones();
        for (int k = 0; k < N; k++) begin
            @(posedge clk); #1;
            for (int c = 0; c < N; c++) begin
                exp_f[c] = (c <= k) ? post_f[c] : pre_f[c];
                exp_d[c] = (c <= k) ? post_d[c] : pre_d[c];
            end
            compared++;
            if (frame_out !== exp_f || done_out !== exp_d) begin
                mismatched++;
                $display("FAIL scan_step k=%0d: got f=%h d=%b want f=%h d=%b",
                         k, frame_out, done_out, exp_f, exp_d);
            end
            compared++;
            if (update_done !== (k == N - 1)) begin
                mismatched++;
                $display("FAIL update_done k=%0d: got %0b want %0b", k, update_done, k == N - 1);
            end
        end
        compared++;
        if (cfg_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL scan_end_ready: got %0b want 1", cfg_ready);
        end
    endtask

    task automatic check_all_zero(input string tag);
        compared++;
        if (frame_out !== '0 || done_out !== '0 || update_done !== 1'b0 ||
            overrun !== 8'd0 || cfg_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s: got f=%h d=%b ud=%0b ov=%0d rdy=%0b want all 0, rdy=1",
                     tag, frame_out, done_out, update_done, overrun, cfg_ready);
        end
    endtask

    task automatic test_reset();
        reset_model();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("reset_released");
    endtask

    task automatic test_idle_scans();
        for (int i = 0; i < 3; i++) run_frame(1'b0, 0, 0, 0, 0);
        compared++;
        if (frame_out !== '0 || done_out !== '0) begin
            mismatched++;
            $display("FAIL idle_scans: got f=%h d=%b want 0", frame_out, done_out);
        end
    endtask

    task automatic test_loop();
        int tab [12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
        do_cfg(0, 1, 4, 0);
        for (int i = 0; i < 12; i++) begin
            run_frame(1'b0, 0, 0, 0, 0);
            compared++;
            if (int'(frame_out[0]) != tab[i]) begin
                mismatched++;
                $display("FAIL loop_seq[%0d]: got %0d want %0d", i, frame_out[0], tab[i]);
            end
        end
    endtask

    task automatic test_pingpong();
        int tab [16] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2, 1, 1, 0};
        do_cfg(1, 2, 4, 1);
        for (int i = 0; i < 16; i++) begin
            run_frame(1'b0, 0, 0, 0, 0);
            compared++;
            if (int'(frame_out[1]) != tab[i]) begin
                mismatched++;
                $display("FAIL pingpong_seq[%0d]: got %0d want %0d", i, frame_out[1], tab[i]);
            end
        end
    endtask

    task automatic test_oneshot();
        int ftab [5] = '{1, 2, 2, 2, 2};
        int dtab [5] = '{0, 1, 1, 1, 1};
        do_cfg(2, 3, 2, 0);
        for (int i = 0; i < 5; i++) begin
            run_frame(1'b0, 0, 0, 0, 0);
            compared++;
            if (int'(frame_out[2]) != ftab[i] || int'(done_out[2]) != dtab[i]) begin
                mismatched++;
                $display("FAIL oneshot_seq[%0d]: got f=%0d d=%0b want f=%0d d=%0d",
                         i, frame_out[2], done_out[2], ftab[i], dtab[i]);
            end
        end
        do_cfg(2, 3, 2, 0);
        compared++;
        if (frame_out[2] !== 3'd0 || done_out[2] !== 1'b0) begin
            mismatched++;
            $display("FAIL oneshot_reconfig: got f=%0d d=%0b want 0 0", frame_out[2], done_out[2]);
        end
    endtask

    task automatic test_clamp_and_range();
        do_cfg(3, 1, 7, 0);
        for (int i = 0; i < 12; i++) begin
            run_frame(1'b0, 0, 0, 0, 0);
            compared++;
            if (frame_out[3] > 3'd4) begin
                mismatched++;
                $display("FAIL clamp: got %0d want <=4", frame_out[3]);
            end
        end
        do_cfg(N, 1, 3, 0);
        do_cfg(7, 3, 1, 2);
        run_frame(1'b1, N, 2, 4, 0);
    endtask

    task automatic test_random();
        int ch, mode, last, period;
        for (int i = 0; i < 40; i++) begin
            ch     = $urandom_range(0, 7);
            mode   = $urandom_range(0, 3);
            last   = $urandom_range(0, 7);
            period = $urandom_range(0, 2);
            case ($urandom_range(0, 2))
                0: do_cfg(ch, mode, last, period);
                1: run_frame(1'b1, ch, mode, last, period);
                default: run_frame(1'b0, 0, 0, 0, 0);
            endcase
        end
    endtask

    task automatic test_overrun(input int spacing, input int cycles);
        int  busy = 0;
        int  want;
        bit  p;
        int  waited;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            p = ((cyc % spacing) == 0);
            new_frame = p;
            @(posedge clk); #1;
            if (busy > 0) begin
                if (p) m_drops++;
                busy--;
            end else if (p) begin
                busy = N;
                for (int c = 0; c < N; c++) m_n[c]++;
            end
            want = (m_drops > 255) ? 255 : m_drops;
            compared++;
            if (int'(overrun) != want) begin
                mismatched++;
                $display("FAIL overrun cyc=%0d: got %0d want %0d", cyc, overrun, want);
            end
        end
        new_frame = 1'b0;
        waited = 0;
        while (cfg_ready !== 1'b1 && waited < N + 2) begin
            @(posedge clk); #1;
            waited++;
        end
        compared++;
        if (cfg_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL overrun_drain: got rdy=%0b want 1", cfg_ready);
        end
        compared++;
        if (frame_out !== model_frames() || done_out !== model_dones()) begin
            mismatched++;
            $display("FAIL overrun_frames: got f=%h d=%b want f=%h d=%b",
                     frame_out, done_out, model_frames(), model_dones());
        end
    endtask

    task automatic test_reset_midscan();
        do_cfg(0, 1, 4, 0);
        do_cfg(4, 2, 3, 0);
        run_frame(1'b0, 0, 0, 0, 0);
        run_frame(1'b0, 0, 0, 0, 0);
        new_frame = 1'b1;
        @(posedge clk); #1;
        new_frame = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_midscan");
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        @(posedge clk); #1;
        check_all_zero("after_midscan_reset");
        run_frame(1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_idle_scans();
        test_loop();
        test_pingpong();
        test_oneshot();
        test_clamp_and_range();
        test_random();
        test_overrun(4, 40);
        test_overrun(1, 320);
        compared++;
        if (overrun !== 8'd255) begin
            mismatched++;
            $display("FAIL overrun_saturate: got %0d want 255", overrun);
        end
        test_random();
        test_reset_midscan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
